// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver (8-N-1) feeding a show-ahead receive FIFO.
// Optional macro UART_RX_PARITY_EN: 8-E-1 frames plus a parity_err_o pulse output.
module uart_rx_fifo #(
  parameter int BAUD_DIV   = 43,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       rx_i,
  input  logic       rd_i,
  output logic [7:0] rdata_o,
  output logic       rvalid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err_o,
`endif
  output logic       busy_o
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q, rx_prev_q;
  logic [BW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [OW-1:0]   os_cnt_q, os_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
  logic            parity_q, parity_d;
  logic            parity_err_q, perr_d;
`endif
  logic            frame_err_q, ferr_d;
  logic            overrun_q, ovr_d;
  logic            tick, sample, fall, push_req;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop, full;

  always_comb begin
    tick   = (baud_cnt_q == BW'(BAUD_DIV - 1));
    sample = tick && (os_cnt_q == OW'(OVERSAMPLE / 2 - 1));
    fall   = rx_prev_q && !rx_s_q;
  end

  // NOTE: every output of this block is assigned a default first, so no path leaves a latch.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = tick ? '0 : baud_cnt_q + 1'b1;
    os_cnt_d   = os_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    push_req   = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_d   = parity_q;
    perr_d     = 1'b0;
`endif
    if (tick) begin
      os_cnt_d = (os_cnt_q == OW'(OVERSAMPLE - 1)) ? '0 : os_cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d    = S_START;
          baud_cnt_d = '0;
          os_cnt_d   = '0;
        end
      end
      S_START: begin
        if (sample) begin
          state_d   = rx_s_q ? S_IDLE : S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
`ifdef UART_RX_PARITY_EN
          parity_d = rx_s_q;
`endif
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          state_d = S_IDLE;
          if (!rx_s_q) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (^{shift_q, parity_q}) begin
            perr_d = 1'b1;
`endif
          end else begin
            push_req = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    full     = (count_q == (AW + 1)'(FIFO_DEPTH));
    do_pop   = rd_i && (count_q != '0);
    do_push  = push_req && (!full || do_pop);
    ovr_d    = push_req && full && !do_pop;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= S_IDLE;
      baud_cnt_q   <= '0;
      os_cnt_q     <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
`ifdef UART_RX_PARITY_EN
      parity_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      // NOTE: the buffer is reset too, because rdata_o reads the head entry directly and must be 0 out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rx_meta_q    <= rx_i;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      os_cnt_q     <= os_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
`ifdef UART_RX_PARITY_EN
      parity_q     <= parity_d;
      parity_err_q <= perr_d;
`endif
      frame_err_q  <= ferr_d;
      overrun_q    <= ovr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign rdata_o     = mem_q[rd_ptr_q];
  assign rvalid_o    = (count_q != '0);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule
